// File: rtl/sort_pkg.sv
// sort_pkg: shared state encoding, default sizes and packed-slice helper for the sort engine
package sort_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SORT_NUM_ELEM = 5;
    localparam int SORT_ELEM_W   = 4;

    // LSB position of element idx inside a packed vector of w-bit elements
    function automatic int elem_lsb(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/sort_cas.sv
// sort_cas: combinational compare-swap of two unsigned values; equal values never swap
module sort_cas #(
    parameter int W         = 4,
    parameter bit ASCENDING = 1'b1
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] lo_o,
    output logic [W-1:0] hi_o
);

    logic swap;

    assign swap = ASCENDING ? (a_i > b_i) : (a_i < b_i);
    assign lo_o = swap ? b_i : a_i;
    assign hi_o = swap ? a_i : b_i;

endmodule

// File: rtl/sort5_engine.sv
// sort5_engine: parallel-load odd-even transposition sorter, one pass per clock
module sort5_engine
    import sort_pkg::*;
#(
    parameter int NUM_ELEM  = SORT_NUM_ELEM,
    parameter int ELEM_W    = SORT_ELEM_W,
    parameter bit ASCENDING = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       iStart,
    input  logic [NUM_ELEM*ELEM_W-1:0] iData,
    output logic [NUM_ELEM*ELEM_W-1:0] oSorted,
    output logic                       oBusy,
    output logic                       oDone
);

    localparam int DW = NUM_ELEM * ELEM_W;
    localparam int CW = $clog2(NUM_ELEM + 1);

    state_t          state_q, state_d;
    logic [DW-1:0]   work_q, work_d;
    logic [DW-1:0]   sorted_q, sorted_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [DW-1:0]   even_res, odd_res, pass_res;

    // even layer: pairs (0,1),(2,3),...; a trailing odd element passes through
    for (genvar k = 0; k < NUM_ELEM / 2; k++) begin : g_even
        sort_cas #(.W(ELEM_W), .ASCENDING(ASCENDING)) u_cas (
            .a_i (work_q[elem_lsb(2*k, ELEM_W) +: ELEM_W]),
            .b_i (work_q[elem_lsb(2*k+1, ELEM_W) +: ELEM_W]),
            .lo_o(even_res[elem_lsb(2*k, ELEM_W) +: ELEM_W]),
            .hi_o(even_res[elem_lsb(2*k+1, ELEM_W) +: ELEM_W])
        );
    end
    if (NUM_ELEM % 2 == 1) begin : g_even_tail
        assign even_res[elem_lsb(NUM_ELEM-1, ELEM_W) +: ELEM_W] = work_q[elem_lsb(NUM_ELEM-1, ELEM_W) +: ELEM_W];
    end

    // odd layer: pairs (1,2),(3,4),...; element 0 and an even-count tail pass through
    for (genvar k = 0; k < (NUM_ELEM - 1) / 2; k++) begin : g_odd
        sort_cas #(.W(ELEM_W), .ASCENDING(ASCENDING)) u_cas (
            .a_i (work_q[elem_lsb(2*k+1, ELEM_W) +: ELEM_W]),
            .b_i (work_q[elem_lsb(2*k+2, ELEM_W) +: ELEM_W]),
            .lo_o(odd_res[elem_lsb(2*k+1, ELEM_W) +: ELEM_W]),
            .hi_o(odd_res[elem_lsb(2*k+2, ELEM_W) +: ELEM_W])
        );
    end
    assign odd_res[ELEM_W-1:0] = work_q[ELEM_W-1:0];
    if (NUM_ELEM % 2 == 0) begin : g_odd_tail
        assign odd_res[elem_lsb(NUM_ELEM-1, ELEM_W) +: ELEM_W] = work_q[elem_lsb(NUM_ELEM-1, ELEM_W) +: ELEM_W];
    end

    assign pass_res = cnt_q[0] ? odd_res : even_res;

    // next state: run passes while sorting, otherwise accept a start pulse
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        sorted_d = sorted_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = done_q;
        if (state_q == SORT) begin
            work_d = pass_res;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(NUM_ELEM - 1)) begin
                sorted_d = pass_res;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                state_d  = DONE;
            end
        end else if (iStart) begin
            work_d  = iData;
            cnt_d   = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            state_d = SORT;
        end
    end

    // state registers; reset aborts any sort in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            work_q   <= '0;
            sorted_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            sorted_q <= sorted_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign oSorted = sorted_q;
    assign oBusy   = busy_q;
    assign oDone   = done_q;

endmodule

// File: tb/tb_sort5_engine.sv
// tb_sort5_engine: scenario tests of the sorter against a queue-sort reference model
module tb_sort5_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iStart = 1'b0;
    logic [19:0] iData = '0;
    logic [15:0] iData4 = '0;
    logic [19:0] sorted, sorted_dsc;
    logic [15:0] sorted4;
    logic        busy, done, busy_dsc, done_dsc, busy4, done4;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    sort5_engine dut (
        .clk(clk), .rst(rst), .iStart(iStart), .iData(iData),
        .oSorted(sorted), .oBusy(busy), .oDone(done)
    );

    sort5_engine #(.ASCENDING(1'b0)) dut_dsc (
        .clk(clk), .rst(rst), .iStart(iStart), .iData(iData),
        .oSorted(sorted_dsc), .oBusy(busy_dsc), .oDone(done_dsc)
    );

    sort5_engine #(.NUM_ELEM(4)) dut4 (
        .clk(clk), .rst(rst), .iStart(iStart), .iData(iData4),
        .oSorted(sorted4), .oBusy(busy4), .oDone(done4)
    );

    // reference: unpack n nibbles, sort as integers, repack
    function automatic logic [19:0] ref_sort(input logic [19:0] d, input int n, input bit asc);
        int v[$];
        logic [19:0] r = '0;
        for (int i = 0; i < n; i++) v.push_back(int'(d[i*4 +: 4]));
        v.sort();
        if (!asc) v.reverse();
        for (int i = 0; i < n; i++) r[i*4 +: 4] = 4'(v[i]);
        return r;
    endfunction

    // pulse start, scramble iData during the sort, optionally re-pulse start at cycle ign
    task automatic run_sort(input logic [19:0] d, input logic [15:0] d4, input int ign, input string nm);
        logic [19:0] e, ed, prev;
        logic [15:0] e4;
        e    = ref_sort(d, 5, 1'b1);
        ed   = ref_sort(d, 5, 1'b0);
        e4   = 16'(ref_sort({4'h0, d4}, 4, 1'b1));
        prev = sorted;
        iData  = d;
        iData4 = d4;
        iStart = 1'b1;
        @(negedge clk);
        iStart = 1'b0;
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++;
            $display("FAIL %s accept busy/done got %b%b want 10", nm, busy, done);
        end
        checks++;
        if (sorted !== prev) begin
            errors++;
            $display("FAIL %s accept hold got %h want %h", nm, sorted, prev);
        end
        for (int c = 1; c <= 5; c++) begin
            iData  = 20'($urandom);
            iData4 = 16'($urandom);
            if (c == ign) iStart = 1'b1;
            @(negedge clk);
            iStart = 1'b0;
            if (c == 4) begin
                checks++;
                if ({done4, sorted4} !== {1'b1, e4}) begin
                    errors++;
                    $display("FAIL %s n4 done/result got %b %h want 1 %h", nm, done4, sorted4, e4);
                end
            end
            if (c < 5) begin
                checks++;
                if ({busy, done} !== 2'b10) begin
                    errors++;
                    $display("FAIL %s cycle %0d busy/done got %b%b want 10", nm, c, busy, done);
                end
            end
        end
        checks++;
        if ({busy, done} !== 2'b01) begin
            errors++;
            $display("FAIL %s finish busy/done got %b%b want 01", nm, busy, done);
        end
        checks++;
        if (sorted !== e) begin
            errors++;
            $display("FAIL %s result got %h want %h", nm, sorted, e);
        end
        checks++;
        if (sorted_dsc !== ed) begin
            errors++;
            $display("FAIL %s descending result got %h want %h", nm, sorted_dsc, ed);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({sorted, busy, done, sorted_dsc, sorted4} !== '0) begin
            errors++;
            $display("FAIL reset outputs got %h %b %b want all zero", sorted, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL idle busy/done got %b%b want 00", busy, done);
        end
    endtask

    task automatic test_directed();
        run_sort(20'h39175, 16'h2413, 0, "mixed");
        run_sort(20'h01234, 16'h1234, 0, "reverse");
        run_sort(20'h43210, 16'h4321, 0, "presorted");
        run_sort(20'hFF0F0, 16'hF0F0, 0, "dups");
        run_sort(20'h77777, 16'h7777, 0, "all_equal");
        run_sort(20'h00000, 16'hFFFF, 0, "extremes");
    endtask

    task automatic test_start_while_busy();
        run_sort(20'h39175, 16'h2413, 2, "busy_start");
    endtask

    task automatic test_done_hold_restart();
        logic [19:0] held;
        held = sorted;
        repeat (4) @(negedge clk);
        checks++;
        if ({busy, done, sorted} !== {2'b01, held}) begin
            errors++;
            $display("FAIL done_hold got %b%b %h want 01 %h", busy, done, sorted, held);
        end
        run_sort(20'hA5C3E, 16'h9C0A, 0, "restart");
    endtask

    task automatic test_reset_mid();
        iData  = 20'h39175;
        iStart = 1'b1;
        @(negedge clk);
        iStart = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({sorted, busy, done} !== '0) begin
            errors++;
            $display("FAIL mid_reset got %h %b%b want 0 00", sorted, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL post_reset idle got %b%b want 00", busy, done);
        end
        run_sort(20'h39175, 16'h2413, 0, "after_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++)
            run_sort(20'($urandom), 16'($urandom), (n % 3 == 0) ? int'($urandom_range(1, 4)) : 0, "random");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_while_busy();
        test_done_hold_restart();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
